// File: rtl/frame_checker_impl.sv
// Receive-side test-frame checker: consumes every beat of the MAC RX stream,
// classifies each frame, validates the IPv4 header checksum and length of test
// frames, and keeps per-port statistics counters.

package frame_checker_pkg;

  // Addresses configured for one tester port.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } port_config_t;

  // Header markers that identify frames produced by the test-frame generator.
  localparam logic [7:0] TEST_FRAME_TOS   = 8'hB4;
  localparam logic [7:0] TEST_FRAME_PROTO = 8'hFD;

endpackage

module frame_checker_impl
  import frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int CNT_WIDTH  = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  port_config_t              port_config,
  input  logic [DATA_WIDTH-1:0]     axis_s_data,
  input  logic [DATA_WIDTH/8-1:0]   axis_s_keep,
  input  logic                      axis_s_last,
  input  logic [DATA_WIDTH/8-1:0]   axis_s_user,
  input  logic [ID_WIDTH-1:0]       axis_s_id,
  input  logic                      axis_s_valid,
  output logic                      axis_s_ready,
  output logic [CNT_WIDTH-1:0]      rx_frames,
  output logic [CNT_WIDTH-1:0]      rx_bytes,
  output logic [CNT_WIDTH-1:0]      test_frames,
  output logic [CNT_WIDTH-1:0]      good_frames,
  output logic [CNT_WIDTH-1:0]      err_checksum,
  output logic [CNT_WIDTH-1:0]      err_length,
  output logic [CNT_WIDTH-1:0]      err_mac
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_BODY  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Byte i of the beat (byte 0 sits in the low bits).
  function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input int i);
    return d[8*i +: 8];
  endfunction

  // Number of valid bytes in a beat.
  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + 16'(k[i]);
    return n;
  endfunction

  // One's-complement check over the 20-byte IPv4 header (checksum included).
  // Ten 16-bit words fit in 20 bits; two folds absorb every carry.
  function automatic logic csum_ok(input logic [159:0] h);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [16:0] fold2;
    sum = '0;
    for (int k = 0; k < 10; k++) sum = sum + {4'h0, h[16*k +: 8], h[16*k+8 +: 8]};
    fold1 = {1'b0, sum[15:0]} + {13'h0, sum[19:16]};
    fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
    return fold2[15:0] == 16'hFFFF;
  endfunction

  // MAC addresses, payload bits and tid carry nothing this block needs.
  logic unused_inputs;
  assign unused_inputs = ^{axis_s_id, axis_s_data[DATA_WIDTH-1:272], axis_s_data[95:0]};

  logic [0:0]           state_q, state_d;
  logic                 is_test_q, is_test_d;
  logic                 csum_ok_q, csum_ok_d;
  logic [15:0]          ip_len_q, ip_len_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;

  logic [CNT_WIDTH-1:0] rx_frames_q, rx_frames_d;
  logic [CNT_WIDTH-1:0] rx_bytes_q, rx_bytes_d;
  logic [CNT_WIDTH-1:0] test_frames_q, test_frames_d;
  logic [CNT_WIDTH-1:0] good_frames_q, good_frames_d;
  logic [CNT_WIDTH-1:0] err_checksum_q, err_checksum_d;
  logic [CNT_WIDTH-1:0] err_length_q, err_length_d;
  logic [CNT_WIDTH-1:0] err_mac_q, err_mac_d;

  logic        beat_acc;
  logic        is_first;
  logic        first_is_test;
  logic        first_csum_ok;
  logic [15:0] first_ip_len;
  logic [16:0] byte_sum;
  logic [15:0] frame_bytes;
  logic        cur_is_test;
  logic        cur_csum_ok;
  logic [15:0] cur_ip_len;
  logic        len_ok;
  logic        mac_err;
  logic        count_evt;

  assign axis_s_ready = !rst;

  // Parse the stream, classify frames and compute next counter values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    is_test_d      = is_test_q;
    csum_ok_d      = csum_ok_q;
    ip_len_d       = ip_len_q;
    byte_cnt_d     = byte_cnt_q;
    rx_frames_d    = rx_frames_q;
    rx_bytes_d     = rx_bytes_q;
    test_frames_d  = test_frames_q;
    good_frames_d  = good_frames_q;
    err_checksum_d = err_checksum_q;
    err_length_d   = err_length_q;
    err_mac_d      = err_mac_q;

    beat_acc = axis_s_valid && axis_s_ready;
    is_first = (state_q == ST_FIRST);

    // Header classification; only meaningful on a first beat.
    first_is_test = (byte_at(axis_s_data, 12) == 8'h08)
                 && (byte_at(axis_s_data, 13) == 8'h00)
                 && (byte_at(axis_s_data, 14) == 8'h45)
                 && (byte_at(axis_s_data, 15) == TEST_FRAME_TOS)
                 && (byte_at(axis_s_data, 23) == TEST_FRAME_PROTO)
                 && ({byte_at(axis_s_data, 26), byte_at(axis_s_data, 27),
                      byte_at(axis_s_data, 28), byte_at(axis_s_data, 29)} == port_config.dst_ip)
                 && ({byte_at(axis_s_data, 30), byte_at(axis_s_data, 31),
                      byte_at(axis_s_data, 32), byte_at(axis_s_data, 33)} == port_config.src_ip)
                 && (&axis_s_keep[33:0]);
    first_csum_ok = csum_ok(axis_s_data[271:112]);
    first_ip_len  = {byte_at(axis_s_data, 16), byte_at(axis_s_data, 17)};

    // Running byte count including this beat, saturating at 16 bits.
    byte_sum    = is_first ? {1'b0, popcount(axis_s_keep)}
                           : {1'b0, byte_cnt_q} + {1'b0, popcount(axis_s_keep)};
    frame_bytes = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    // A single-beat frame must use this beat's header, not stale latched flags.
    cur_is_test = is_first ? first_is_test : is_test_q;
    cur_csum_ok = is_first ? first_csum_ok : csum_ok_q;
    cur_ip_len  = is_first ? first_ip_len  : ip_len_q;
    len_ok      = ({1'b0, frame_bytes} == ({1'b0, cur_ip_len} + 17'd14));
    mac_err     = |axis_s_user;
    count_evt   = beat_acc && axis_s_last && enable;

    if (beat_acc) begin
      byte_cnt_d = frame_bytes;
      if (is_first) begin
        is_test_d = first_is_test;
        csum_ok_d = first_csum_ok;
        ip_len_d  = first_ip_len;
      end
      state_d = axis_s_last ? ST_FIRST : ST_BODY;
    end

    if (clear) begin
      rx_frames_d    = '0;
      rx_bytes_d     = '0;
      test_frames_d  = '0;
      good_frames_d  = '0;
      err_checksum_d = '0;
      err_length_d   = '0;
      err_mac_d      = '0;
    end else if (count_evt) begin
      rx_frames_d = rx_frames_q + CNT_ONE;
      rx_bytes_d  = rx_bytes_q + {{(CNT_WIDTH-16){1'b0}}, frame_bytes};
      if (mac_err) begin
        err_mac_d = err_mac_q + CNT_ONE;
      end else if (cur_is_test) begin
        test_frames_d = test_frames_q + CNT_ONE;
        if (!cur_csum_ok) err_checksum_d = err_checksum_q + CNT_ONE;
        if (!len_ok)      err_length_d   = err_length_q + CNT_ONE;
        if (cur_csum_ok && len_ok) good_frames_d = good_frames_q + CNT_ONE;
      end
    end
  end

  // Register parser state, latched header flags and statistics.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q        <= ST_FIRST;
      is_test_q      <= 1'b0;
      csum_ok_q      <= 1'b0;
      ip_len_q       <= '0;
      byte_cnt_q     <= '0;
      rx_frames_q    <= '0;
      rx_bytes_q     <= '0;
      test_frames_q  <= '0;
      good_frames_q  <= '0;
      err_checksum_q <= '0;
      err_length_q   <= '0;
      err_mac_q      <= '0;
    end else begin
      state_q        <= state_d;
      is_test_q      <= is_test_d;
      csum_ok_q      <= csum_ok_d;
      ip_len_q       <= ip_len_d;
      byte_cnt_q     <= byte_cnt_d;
      rx_frames_q    <= rx_frames_d;
      rx_bytes_q     <= rx_bytes_d;
      test_frames_q  <= test_frames_d;
      good_frames_q  <= good_frames_d;
      err_checksum_q <= err_checksum_d;
      err_length_q   <= err_length_d;
      err_mac_q      <= err_mac_d;
    end
  end

  assign rx_frames    = rx_frames_q;
  assign rx_bytes     = rx_bytes_q;
  assign test_frames  = test_frames_q;
  assign good_frames  = good_frames_q;
  assign err_checksum = err_checksum_q;
  assign err_length   = err_length_q;
  assign err_mac      = err_mac_q;

endmodule

// File: tb/tb_frame_checker_impl.sv
// Directed bench for frame_checker_impl: builds frames byte by byte, streams
// them in 64-byte beats and compares the statistics counters with hand-derived
// totals.

module tb_frame_checker_impl;
  import frame_checker_pkg::*;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 48;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           clear;
  port_config_t   cfg;
  logic [DW-1:0]  axis_s_data;
  logic [KW-1:0]  axis_s_keep;
  logic           axis_s_last;
  logic [KW-1:0]  axis_s_user;
  logic [2:0]     axis_s_id;
  logic           axis_s_valid;
  logic           axis_s_ready;
  logic [CW-1:0]  rx_frames, rx_bytes, test_frames, good_frames;
  logic [CW-1:0]  err_checksum, err_length, err_mac;

  int n_checks = 0;
  int n_pass   = 0;
  bit ready_low_seen;
  logic [7:0] fbuf [0:2047];

  frame_checker_impl #(.DATA_WIDTH(DW), .ID_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (clear),
    .port_config  (cfg),
    .axis_s_data  (axis_s_data),
    .axis_s_keep  (axis_s_keep),
    .axis_s_last  (axis_s_last),
    .axis_s_user  (axis_s_user),
    .axis_s_id    (axis_s_id),
    .axis_s_valid (axis_s_valid),
    .axis_s_ready (axis_s_ready),
    .rx_frames    (rx_frames),
    .rx_bytes     (rx_bytes),
    .test_frames  (test_frames),
    .good_frames  (good_frames),
    .err_checksum (err_checksum),
    .err_length   (err_length),
    .err_mac      (err_mac)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_counters(input string tag, input int rxf, input int rxb, input int tf,
                                input int gf, input int ec, input int el, input int em);
    check({tag, " rx_frames"},    64'(rx_frames),    64'(rxf));
    check({tag, " rx_bytes"},     64'(rx_bytes),     64'(rxb));
    check({tag, " test_frames"},  64'(test_frames),  64'(tf));
    check({tag, " good_frames"},  64'(good_frames),  64'(gf));
    check({tag, " err_checksum"}, 64'(err_checksum), 64'(ec));
    check({tag, " err_length"},   64'(err_length),   64'(el));
    check({tag, " err_mac"},      64'(err_mac),      64'(em));
  endtask

  // Fill fbuf with a frame whose IP header addresses match this port's loopback.
  task automatic build_frame(input int nbytes, input int ip_len, input logic [15:0] etype);
    logic [31:0] s;
    logic [15:0] cks;
    for (int i = 0; i < 2048; i++) fbuf[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 12; i++) fbuf[i] = 8'h10 + 8'(i);
    fbuf[12] = etype[15:8];  fbuf[13] = etype[7:0];
    fbuf[14] = 8'h45;        fbuf[15] = TEST_FRAME_TOS;
    fbuf[16] = 8'(ip_len >> 8); fbuf[17] = 8'(ip_len);
    fbuf[18] = 8'h12;        fbuf[19] = 8'h34;
    fbuf[20] = 8'h40;        fbuf[21] = 8'h00;
    fbuf[22] = 8'h40;        fbuf[23] = TEST_FRAME_PROTO;
    fbuf[24] = 8'h00;        fbuf[25] = 8'h00;
    fbuf[26] = cfg.dst_ip[31:24]; fbuf[27] = cfg.dst_ip[23:16];
    fbuf[28] = cfg.dst_ip[15:8];  fbuf[29] = cfg.dst_ip[7:0];
    fbuf[30] = cfg.src_ip[31:24]; fbuf[31] = cfg.src_ip[23:16];
    fbuf[32] = cfg.src_ip[15:8];  fbuf[33] = cfg.src_ip[7:0];
    s = 0;
    for (int w = 0; w < 10; w++) s = s + {16'h0, fbuf[14 + 2*w], fbuf[15 + 2*w]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cks = ~s[15:0];
    fbuf[24] = cks[15:8];
    fbuf[25] = cks[7:0];
    if (nbytes < 2048) fbuf[nbytes] = 8'h00;
  endtask

  // Stream fbuf as 64-byte beats, 'gap' idle cycles between beats.
  task automatic send_frame(input int nbytes, input int gap, input logic [KW-1:0] user_last,
                            input bit clr_last, input int max_beats);
    int nbeats;
    int idx;
    nbeats = (nbytes + 63) / 64;
    for (int b = 0; b < nbeats && b < max_beats; b++) begin
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
        idx = b * 64 + i;
        axis_s_data[8*i +: 8] = (idx < nbytes) ? fbuf[idx] : 8'h00;
        axis_s_keep[i]        = (idx < nbytes);
      end
      axis_s_last  = (b == nbeats - 1);
      axis_s_user  = axis_s_last ? user_last : '0;
      clear        = axis_s_last && clr_last;
      axis_s_valid = 1'b1;
      if (!axis_s_ready) ready_low_seen = 1'b1;
      if (gap > 0 && b != nbeats - 1) begin
        @(negedge clk);
        axis_s_valid = 1'b0;
        if (!axis_s_ready) ready_low_seen = 1'b1;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    axis_s_valid = 1'b0;
    axis_s_last  = 1'b0;
    axis_s_user  = '0;
    axis_s_keep  = '0;
    clear        = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    cfg.src_ip = 32'h0A00_0001;
    cfg.dst_ip = 32'h0A00_0002;
    axis_s_data = '0; axis_s_keep = '0; axis_s_last = 1'b0;
    axis_s_user = '0; axis_s_id = 3'd5; axis_s_valid = 1'b0;
    ready_low_seen = 1'b0;

    repeat (3) @(negedge clk);
    check("ready in reset", 64'(axis_s_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", 64'(axis_s_ready), 64'd1);
    check_counters("reset", 0, 0, 0, 0, 0, 0, 0);

    // 60-byte single-beat good frame, IP length 46.
    build_frame(60, 46, 16'h0800);
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("good60", 1, 60, 1, 1, 0, 0, 0);

    // 1514-byte frame in 24 beats with idle gaps.
    pulse_clear();
    ready_low_seen = 1'b0;
    build_frame(1514, 1500, 16'h0800);
    send_frame(1514, 1, '0, 1'b0, 99);
    check_counters("good1514", 1, 1514, 1, 1, 0, 0, 0);
    check("ready held high", 64'(ready_low_seen), 64'd0);

    // Corrupted checksum, then wrong IP length.
    pulse_clear();
    build_frame(60, 46, 16'h0800);
    fbuf[25] = fbuf[25] ^ 8'h01;
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("bad csum", 1, 60, 1, 0, 1, 0, 0);
    build_frame(60, 47, 16'h0800);
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("bad len", 2, 120, 2, 0, 1, 1, 0);

    // Non-test ARP frame, then a MAC-error frame.
    pulse_clear();
    build_frame(64, 46, 16'h0806);
    send_frame(64, 0, '0, 1'b0, 99);
    check_counters("arp", 1, 64, 0, 0, 0, 0, 0);
    build_frame(60, 46, 16'h0800);
    send_frame(60, 0, 64'h1, 1'b0, 99);
    check_counters("mac err", 2, 124, 0, 0, 0, 0, 1);

    // Three good frames, then clear coinciding with a fourth frame's last beat.
    pulse_clear();
    build_frame(60, 46, 16'h0800);
    repeat (3) send_frame(60, 0, '0, 1'b0, 99);
    check_counters("three good", 3, 180, 3, 3, 0, 0, 0);
    send_frame(60, 0, '0, 1'b1, 99);
    check_counters("clear on last", 0, 0, 0, 0, 0, 0, 0);
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("after clear", 1, 60, 1, 1, 0, 0, 0);
    enable = 1'b0;
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("disabled", 1, 60, 1, 1, 0, 0, 0);
    enable = 1'b1;

    // Reset in the middle of a 3-beat frame, then a fresh good frame.
    build_frame(150, 136, 16'h0800);
    send_frame(150, 0, '0, 1'b0, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_counters("mid reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    build_frame(60, 46, 16'h0800);
    send_frame(60, 0, '0, 1'b0, 99);
    check_counters("post reset", 1, 60, 1, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
